prl: RTL and testbench

//  Coarse-to-fine prolongation engine for the multigrid solver; the inverse of the restriction stage.
//  - Reads each cell of a (2^(BOX_IDX-1))^2 coarse grid RAM once.
//  - Writes that value (optionally right-shifted) to its four children in a (2^BOX_IDX)^2 fine grid RAM.
//  - Runs one frame per start pulse and sits between the coarse-level buffer and the fine-level buffer.

---
 rtl/prl_if.sv | 24 ++
 rtl/prl.sv | 100 ++++++++++
 tb/tb_prl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/prl_if.sv
// Bus between the prolongation engine and its coarse/fine grid RAMs and controller.
interface prl_if #(
    parameter int BOX_IDX = 3
) ();
    logic                   start;
    logic                   hold;
    logic [7:0]             x;
    logic [2*BOX_IDX-3:0]   rd_addr;
    logic                   wen_prl;
    logic [2*BOX_IDX-1:0]   wr_addr;
    logic [7:0]             y;
    logic                   busy;
    logic                   done;

    modport slave (
        input  start, hold, x,
        output rd_addr, wen_prl, wr_addr, y, busy, done
    );

    modport master (
        output start, hold, x,
        input  rd_addr, wen_prl, wr_addr, y, busy, done
    );
endinterface

// File: rtl/prl.sv
// Coarse-to-fine prolongation: each coarse cell is read once and copied (optionally
// right-shifted) into its 2x2 block of fine cells, four writes per coarse cell.
module prl #(
    parameter int BOX_IDX   = 3,
    parameter int DIV_SHIFT = 0
) (
    input  logic  CLK,
    input  logic  RST_n,
    prl_if.slave  bus
);
    localparam int CW = BOX_IDX - 1;
    localparam int KW = 2 * CW;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      x_r_q, x_r_d;

    logic [CW-1:0]   cx, cy;
    assign cx = k_q[KW-1:CW];
    assign cy = k_q[CW-1:0];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            k_q     <= '0;
            x_r_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            k_q     <= k_d;
            x_r_q   <= x_r_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        k_d          = k_q;
        x_r_d        = x_r_q;
        bus.rd_addr  = '0;
        bus.wen_prl  = 1'b0;
        bus.wr_addr  = '0;
        bus.y        = 8'd0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    phase_d = 2'd0;
                    k_d     = '0;
                end
            end
            READ: begin
                bus.busy    = 1'b1;
                bus.rd_addr = k_q;
                state_d     = WRITE;
                phase_d     = 2'd0;
            end
            WRITE: begin
                bus.busy    = 1'b1;
                bus.wen_prl = 1'b1;
                bus.rd_addr = k_q;
                // phase bit 0 selects the odd fine column, bit 1 the odd fine row
                bus.wr_addr = {cx, phase_q[0], cy, phase_q[1]};
                if (phase_q == 2'd0) begin
                    bus.y = 8'(bus.x >> DIV_SHIFT);
                    x_r_d = bus.x;
                end else begin
                    bus.y = 8'(x_r_q >> DIV_SHIFT);
                end
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (&k_q) begin
                        state_d = DONE;
                    end else begin
                        // prefetch the next coarse cell so it lands on the next phase 0
                        bus.rd_addr = k_q + 1'b1;
                        k_d         = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.hold) begin
            state_d = IDLE;
            phase_d = 2'd0;
            k_d     = '0;
            x_r_d   = 8'd0;
        end
    end
endmodule

// File: tb/tb_prl.sv
// Directed bench for prl: per-cycle capture of outputs, table-checked key cycles,
// plus abort, reset and back-to-back sequences.
module tb_prl;
    localparam int CAP = 200;

    logic CLK, RST_n;
    prl_if #(.BOX_IDX(3)) a ();
    prl_if #(.BOX_IDX(3)) b ();

    prl #(.BOX_IDX(3), .DIV_SHIFT(0)) dut_a (.CLK(CLK), .RST_n(RST_n), .bus(a.slave));
    prl #(.BOX_IDX(3), .DIV_SHIFT(2)) dut_b (.CLK(CLK), .RST_n(RST_n), .bus(b.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];

    // coarse RAM models: one cycle read latency
    always @(posedge CLK) begin
        a.x <= mem_a[a.rd_addr];
        b.x <= mem_b[b.rd_addr];
    end

    int nchk = 0;
    int nfail = 0;
    int ncyc;

    logic       c_wen  [CAP];
    logic [5:0] c_wa   [CAP];
    logic [7:0] c_y    [CAP];
    logic       c_busy [CAP];
    logic       c_done [CAP];
    logic [3:0] c_rd   [CAP];
    logic       cb_wen [CAP];
    logic [7:0] cb_y   [CAP];
    logic [7:0] fine   [64];

    typedef struct {
        int         n;
        logic       wen;
        logic [5:0] wa;
        logic [7:0] y;
        logic       busy;
        logic       done;
        logic [3:0] rd;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        ncyc++;
        if (ncyc < CAP) begin
            c_wen[ncyc]  = a.wen_prl;
            c_wa[ncyc]   = a.wr_addr;
            c_y[ncyc]    = a.y;
            c_busy[ncyc] = a.busy;
            c_done[ncyc] = a.done;
            c_rd[ncyc]   = a.rd_addr;
            cb_wen[ncyc] = b.wen_prl;
            cb_y[ncyc]   = b.y;
        end
    endtask

    // summarise cycles 1..last of a captured dut_a frame
    task automatic analyze(input int last, output int nw, output int nwin,
                           output int nd, output int dn, output int rmax);
        nw = 0; nwin = 0; nd = 0; dn = -1; rmax = 0;
        for (int i = 0; i < 64; i++) fine[i] = 8'h00;
        for (int n = 1; n <= last; n++) begin
            if (c_wen[n]) begin
                nw++;
                if (n >= 2 && n <= 65) nwin++;
                fine[c_wa[n]] = c_y[n];
            end
            if (c_done[n]) begin nd++; dn = n; end
            if (int'(c_rd[n]) > rmax) rmax = int'(c_rd[n]);
        end
    endtask

    function automatic logic [19:0] outs_a();
        return {a.wen_prl, a.wr_addr, a.y, a.busy, a.done, a.rd_addr};
    endfunction

    initial begin
        int nw, nwin, nd, dn, rmax, nbad;
        logic [2:0] fx, fy;

        tbl[0]  = '{1,  1'b0, 6'h00, 8'd0,  1'b1, 1'b0, 4'd0};
        tbl[1]  = '{2,  1'b1, 6'h00, 8'd1,  1'b1, 1'b0, 4'd0};
        tbl[2]  = '{3,  1'b1, 6'h08, 8'd1,  1'b1, 1'b0, 4'd0};
        tbl[3]  = '{4,  1'b1, 6'h01, 8'd1,  1'b1, 1'b0, 4'd0};
        tbl[4]  = '{5,  1'b1, 6'h09, 8'd1,  1'b1, 1'b0, 4'd1};
        tbl[5]  = '{6,  1'b1, 6'h02, 8'd2,  1'b1, 1'b0, 4'd1};
        tbl[6]  = '{62, 1'b1, 6'h36, 8'd16, 1'b1, 1'b0, 4'd15};
        tbl[7]  = '{63, 1'b1, 6'h3E, 8'd16, 1'b1, 1'b0, 4'd15};
        tbl[8]  = '{64, 1'b1, 6'h37, 8'd16, 1'b1, 1'b0, 4'd15};
        tbl[9]  = '{65, 1'b1, 6'h3F, 8'd16, 1'b1, 1'b0, 4'd15};
        tbl[10] = '{66, 1'b0, 6'h00, 8'd0,  1'b0, 1'b1, 4'd0};

        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'hFF;
        end
        RST_n = 1'b0;
        a.start = 1'b0; a.hold = 1'b0;
        b.start = 1'b0; b.hold = 1'b0;
        a.x = 8'd0; b.x = 8'd0;
        ncyc = 0;
        repeat (2) @(negedge CLK);
        chk("reset_outs_a", 32'(outs_a()), 32'd0);
        RST_n = 1'b1;
        tick();

        // frame with mem[k]=k+1
        a.start = 1'b1; ncyc = 0; tick(); a.start = 1'b0;
        repeat (75) tick();
        foreach (tbl[i]) begin
            chk($sformatf("vec_n%0d", tbl[i].n),
                32'({c_wen[tbl[i].n], c_wa[tbl[i].n], c_y[tbl[i].n],
                     c_busy[tbl[i].n], c_done[tbl[i].n], c_rd[tbl[i].n]}),
                32'({tbl[i].wen, tbl[i].wa, tbl[i].y, tbl[i].busy, tbl[i].done, tbl[i].rd}));
        end
        analyze(76, nw, nwin, nd, dn, rmax);
        chk("f1_writes", 32'(nw), 32'd64);
        chk("f1_writes_in_window", 32'(nwin), 32'd64);
        chk("f1_done_count", 32'(nd), 32'd1);
        chk("f1_done_cycle", 32'(dn), 32'd66);
        chk("f1_rd_max_le15", 32'(rmax <= 15), 32'd1);
        chk("f1_busy_after", 32'(c_busy[67]), 32'd0);
        for (int i = 0; i < 64; i++) begin
            fx = 3'(i >> 3);
            fy = 3'(i & 7);
            chk($sformatf("fine_%0d_%0d", fx, fy), 32'(fine[i]), 32'(mem_a[{fx[2:1], fy[2:1]}]));
        end

        // DIV_SHIFT=2 instance: 0xFF -> 0x3F, then 0x03 -> 0x00
        b.start = 1'b1; ncyc = 0; tick(); b.start = 1'b0;
        repeat (75) tick();
        nw = 0; nbad = 0;
        for (int n = 1; n <= 76; n++) if (cb_wen[n]) begin nw++; if (cb_y[n] != 8'h3F) nbad++; end
        chk("sh_ff_writes", 32'(nw), 32'd64);
        chk("sh_ff_bad_y", 32'(nbad), 32'd0);
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h03;
        b.start = 1'b1; ncyc = 0; tick(); b.start = 1'b0;
        repeat (75) tick();
        nw = 0; nbad = 0;
        for (int n = 1; n <= 76; n++) begin
            if (cb_wen[n]) nw++;
            if (cb_y[n] != 8'h00) nbad++;
        end
        chk("sh_03_writes", 32'(nw), 32'd64);
        chk("sh_03_nonzero_y", 32'(nbad), 32'd0);

        // start re-pulsed during WRITE is ignored
        a.start = 1'b1; ncyc = 0; tick(); a.start = 1'b0;
        repeat (8) tick();
        a.start = 1'b1; tick(); a.start = 1'b0;
        repeat (66) tick();
        analyze(76, nw, nwin, nd, dn, rmax);
        chk("restart_writes", 32'(nw), 32'd64);
        chk("restart_done_count", 32'(nd), 32'd1);
        chk("restart_done_cycle", 32'(dn), 32'd66);

        // start held high: next READ two cycles after done
        a.start = 1'b1; ncyc = 0;
        repeat (70) tick();
        chk("b2b_done", 32'(c_done[66]), 32'd1);
        chk("b2b_idle_gap", 32'({c_busy[67], c_wen[67]}), 32'd0);
        chk("b2b_read2", 32'({c_busy[68], c_wen[68], c_rd[68]}), 32'({1'b1, 1'b0, 4'd0}));
        a.start = 1'b0; a.hold = 1'b1; tick(); a.hold = 1'b0; tick();
        chk("b2b_cleared", 32'(outs_a()), 32'd0);

        // hold during the 20th write aborts without done
        a.start = 1'b1; ncyc = 0; tick(); a.start = 1'b0;
        repeat (20) tick();
        chk("hold_20th_write_live", 32'(c_wen[21]), 32'd1);
        a.hold = 1'b1; tick(); a.hold = 1'b0;
        repeat (60) tick();
        chk("hold_next_cycle", 32'({c_wen[22], c_busy[22], c_rd[22]}), 32'd0);
        analyze(82, nw, nwin, nd, dn, rmax);
        chk("hold_writes", 32'(nw), 32'd20);
        chk("hold_no_done", 32'(nd), 32'd0);
        a.start = 1'b1; ncyc = 0; tick(); a.start = 1'b0;
        repeat (75) tick();
        analyze(76, nw, nwin, nd, dn, rmax);
        chk("posthold_writes", 32'(nw), 32'd64);
        chk("posthold_done_cycle", 32'(dn), 32'd66);
        chk("posthold_first", 32'({c_rd[1], c_wa[2], c_y[2]}), 32'({4'd0, 6'h00, 8'd1}));

        // async reset mid-WRITE
        a.start = 1'b1; ncyc = 0; tick(); a.start = 1'b0;
        repeat (29) tick();
        chk("prerst_writing", 32'(a.wen_prl), 32'd1);
        #1 RST_n = 1'b0;
        #1 chk("async_rst_outs", 32'(outs_a()), 32'd0);
        tick(); tick();
        RST_n = 1'b1;
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (outs_a() != 20'd0) nbad++;
        end
        chk("post_rst_idle", 32'(nbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
